// File: rtl/pwm_drive.sv
`default_nettype none
// ============================================================================
// Module      : pwm_drive
// Description : Period-based PWM driver. A prescaler divides clk into PWM
//               ticks, and a phase counter walks the ticks of each period.
//               The duty value is sampled only at period boundaries, so a
//               period always completes with the duty it started with.
//               Dropping enable lets the current period finish (DRAIN).
//               Raising enable again before the period ends resumes RUN
//               without restarting the period. Rising edges of the upstream
//               ready flag are counted, and the count saturates at 255.
//
// Ports       : clk          - clock, all state updates on the rising edge
//               rst          - asynchronous active-high reset
//               duty_cycle   - requested duty in ticks (clamped to STEPS)
//               ready        - ramp-complete flag from the upstream stage
//               enable       - level request to run the PWM
//               pwm          - PWM drive output
//               period_start - one-cycle pulse on the first cycle of a period
//               duty_applied - duty value in force for the current period
//               busy         - high while in RUN or DRAIN
//               ramp_count   - saturating count of completed upstream ramps
//
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_drive #(
    parameter int PRESCALE = 10,  // clk cycles per PWM tick, 1..255
    parameter int STEPS    = 10   // ticks per period and full-scale duty, 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] duty_cycle,
    input  logic       ready,
    input  logic       enable,
    output logic       pwm,
    output logic       period_start,
    output logic [3:0] duty_applied,
    output logic       busy,
    output logic [7:0] ramp_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [7:0] c_PRE_MAX   = 8'(PRESCALE - 1);
    localparam logic [3:0] c_PHASE_MAX = 4'(STEPS - 1);
    localparam logic [3:0] c_STEPS     = 4'(STEPS);
    localparam logic [7:0] c_RAMP_MAX  = 8'd255;

    // State encoding
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic [7:0] r_prescale;
    logic [3:0] r_phase;
    logic [3:0] r_duty;
    logic       r_period_start;
    logic       r_ready;
    logic [7:0] r_ramp_count;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic       w_busy;
    logic       w_tick;
    logic       w_period_end;
    logic [3:0] w_clamp;
    logic [7:0] w_prescale_adv;
    logic [3:0] w_phase_adv;
    logic       w_ready_rise;

    logic [1:0] w_state_nxt;
    logic [7:0] w_prescale_nxt;
    logic [3:0] w_phase_nxt;
    logic [3:0] w_duty_nxt;
    logic       w_period_start_nxt;

    assign w_busy = (r_state == c_ST_RUN) || (r_state == c_ST_DRAIN);

    // The prescaler stays at 0 while idle. With PRESCALE=1 it never leaves 0,
    // so every cycle is a tick.
    assign w_tick       = (r_prescale == c_PRE_MAX);
    assign w_period_end = w_busy && w_tick && (r_phase == c_PHASE_MAX);

    // Requests above full scale are limited to full scale (constant high).
    assign w_clamp = (duty_cycle > c_STEPS) ? c_STEPS : duty_cycle;

    // Free-running advance of the counters, used while RUN or DRAIN.
    assign w_prescale_adv = w_tick ? 8'd0 : (r_prescale + 8'd1);

    always_comb begin
        w_phase_adv = r_phase;
        if (w_tick) begin
            if (r_phase == c_PHASE_MAX) begin
                w_phase_adv = 4'd0;
            end else begin
                w_phase_adv = r_phase + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state and datapath next values
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_prescale_nxt     = r_prescale;
        w_phase_nxt        = r_phase;
        w_duty_nxt         = r_duty;
        w_period_start_nxt = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (enable) begin
                    // Start a fresh period on the same edge that leaves IDLE.
                    w_state_nxt        = c_ST_RUN;
                    w_prescale_nxt     = 8'd0;
                    w_phase_nxt        = 4'd0;
                    w_duty_nxt         = w_clamp;
                    w_period_start_nxt = 1'b1;
                end
            end

            c_ST_RUN: begin
                w_prescale_nxt = w_prescale_adv;
                w_phase_nxt    = w_phase_adv;
                if (w_period_end) begin
                    w_duty_nxt         = w_clamp;
                    w_period_start_nxt = 1'b1;
                end
                if (!enable) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end

            c_ST_DRAIN: begin
                w_prescale_nxt = w_prescale_adv;
                w_phase_nxt    = w_phase_adv;
                if (w_period_end) begin
                    if (enable) begin
                        // Re-enabled on the boundary: carry on as a normal
                        // period rollover.
                        w_state_nxt        = c_ST_RUN;
                        w_duty_nxt         = w_clamp;
                        w_period_start_nxt = 1'b1;
                    end else begin
                        // Drained: park the counters.
                        // The duty value is left in place.
                        w_state_nxt    = c_ST_IDLE;
                        w_prescale_nxt = 8'd0;
                        w_phase_nxt    = 4'd0;
                    end
                end else if (enable) begin
                    // Resume mid-period without touching the counters.
                    w_state_nxt = c_ST_RUN;
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle.
                w_state_nxt    = c_ST_IDLE;
                w_prescale_nxt = 8'd0;
                w_phase_nxt    = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_prescale     <= 8'd0;
            r_phase        <= 4'd0;
            r_duty         <= 4'd0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_prescale     <= w_prescale_nxt;
            r_phase        <= w_phase_nxt;
            r_duty         <= w_duty_nxt;
            r_period_start <= w_period_start_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Upstream ramp counter: counts rising edges of ready, in any state
    // ------------------------------------------------------------------------
    assign w_ready_rise = ready && !r_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ready      <= 1'b0;
            r_ramp_count <= 8'd0;
        end else begin
            r_ready <= ready;
            if (w_ready_rise && (r_ramp_count != c_RAMP_MAX)) begin
                r_ramp_count <= r_ramp_count + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The PWM output is decoded directly from registers, so it adds no latency.
    // A duty of 0 never satisfies the compare. A duty of STEPS always does.
    assign pwm          = w_busy && (r_phase < r_duty);
    assign busy         = w_busy;
    assign period_start = r_period_start;
    assign duty_applied = r_duty;
    assign ramp_count   = r_ramp_count;

endmodule
`default_nettype wire

// File: doc/pwm_drive.md
PWM_DRIVE -- requirements
Module: pwm_drive

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 10, meaning clk cycles per PWM tick (legal 1..255).
REQ-002 The block SHALL have parameter STEPS, default 10, meaning PWM ticks per period and the full-scale duty value (legal 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port duty_cycle, input, 4 bits: requested duty in ticks, from the upstream ramp stage.
REQ-006 The block SHALL have port ready, input, 1 bit: ramp-complete flag from the upstream ramp stage.
REQ-007 The block SHALL have port enable, input, 1 bit: level request to run PWM.
REQ-008 The block SHALL have port pwm, output, 1 bit: PWM drive.
REQ-009 The block SHALL have port period_start, output, 1 bit: one-cycle pulse at the start of each period.
REQ-010 The block SHALL have port duty_applied, output, 4 bits: duty value in force for the current period.
REQ-011 The block SHALL have port busy, output, 1 bit: high while the FSM is in RUN or DRAIN.
REQ-012 The block SHALL have port ramp_count, output, 8 bits: count of completed upstream ramps.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DRAIN, held in registers.
REQ-014 An 8-bit prescaler SHALL count 0..PRESCALE-1 and wrap; tick SHALL be asserted on the cycle the prescaler equals PRESCALE-1 (every cycle when PRESCALE=1).
REQ-015 A 4-bit phase counter SHALL advance on each tick and wrap from STEPS-1 to 0; period_end = tick AND phase==STEPS-1.
REQ-016 IDLE->RUN on enable=1: the same edge SHALL load prescaler=0, phase=0, duty_applied=clamp(duty_cycle), and register period_start=1.
REQ-017 clamp(x) SHALL equal STEPS when x>STEPS, otherwise x.
REQ-018 In RUN/DRAIN at period_end, duty_applied SHALL be reloaded with clamp(duty_cycle) and period_start SHALL pulse for exactly one cycle.
REQ-019 duty_cycle changes within a period SHALL NOT affect the current period.
REQ-020 pwm SHALL be a combinational decode of registers: 1 iff busy AND phase<duty_applied, with no extra latency.
REQ-021 duty_applied=0 SHALL give constant pwm=0; duty_applied=STEPS SHALL give constant pwm=1.
REQ-022 RUN->DRAIN on enable=0; counters SHALL keep running.
REQ-023 DRAIN->RUN on enable=1 before period_end, with no period restart.
REQ-024 DRAIN->IDLE at period_end with enable=0; on this transition period_start SHALL NOT pulse, and counters SHALL clear to 0.
REQ-025 If period_end and enable=1 coincide in DRAIN, the block SHALL enter RUN and behave as REQ-018.
REQ-026 In IDLE, pwm=0 and period_start=0, and duty_applied SHALL hold its last value.
REQ-027 ready SHALL be registered into ready_r; a rising edge (ready AND NOT ready_r) SHALL increment ramp_count in any state, saturating at 255.
REQ-028 ready held high for multiple cycles SHALL count once.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, prescaler=0, phase=0, duty_applied=0, period_start=0, ramp_count=0, ready_r=0, which makes pwm=0 and busy=0.
REQ-030 Reset asserted mid-period SHALL abort the period with no further period_start; operation SHALL resume only via REQ-016 after release.

Verification (PRESCALE=2, STEPS=10, period = 20 clk)
REQ-031 Assert rst mid-run with pwm=1 -> pwm, busy, period_start, duty_applied and ramp_count all 0 before the next clk edge.
REQ-032 duty_cycle=3, enable=1 -> each period gives pwm high for 6 clk then low for 14, and period_start pulses every 20 clk.
REQ-033 duty_cycle changed from 3 to 7 at phase 5 -> current period stays at 6 high; next period gives 14 high and duty_applied=7.
REQ-034 duty_cycle=12 -> duty_applied=10 and pwm constant 1; duty_cycle=0 -> pwm constant 0 from the next period.
REQ-035 enable dropped at phase 4 -> busy=1 until the period completes, then IDLE with pwm=0 and no further period_start; re-assert at phase 7 -> period continues uninterrupted.
REQ-036 300 single-cycle ready pulses -> ramp_count=255; one ready held high for 5 clk -> increment of exactly 1.
